// File: rtl/norm_seq.sv
// rtl/norm_seq.sv - sequential floating-point normalizer, one bit of shift per cycle
// Optional STICKY output (OR of right-shifted-out bits) is enabled by defining NORM_SEQ_STICKY_EN.
module norm_seq (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  scale_in_i,
    input  logic [12:0] frac_in_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  scale_out_o,
    output logic [10:0] frac_out_o,
    output logic        zero_o,
    output logic        ovf_o,
    output logic        uf_o
`ifdef NORM_SEQ_STICKY_EN
    ,
    output logic        sticky_o
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] SCALE_MAX = 5'b01111;
    localparam logic [4:0] SCALE_MIN = 5'b10000;

    state_t      state_q, state_d;
    logic [4:0]  scale_q, scale_d;
    logic [12:0] w_q, w_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic        uf_q, uf_d;
    logic        sticky_q, sticky_d;
    logic        normalized;

    assign normalized = (w_q[12:11] == 2'b00) && w_q[10];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            scale_q  <= 5'd0;
            w_q      <= 13'd0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            uf_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            scale_q  <= scale_d;
            w_q      <= w_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            uf_q     <= uf_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        scale_d  = scale_q;
        w_d      = w_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        uf_d     = uf_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    scale_d  = scale_in_i;
                    w_d      = frac_in_i;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    uf_d     = 1'b0;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (w_q == 13'd0) begin
                    zero_d  = 1'b1;
                    scale_d = SCALE_MIN;
                    state_d = DONE;
                end else if (normalized) begin
                    state_d = DONE;
                end else if (w_q[12:11] != 2'b00) begin
                    // Saturate rather than let the scale wrap past +15.
                    if (scale_q == SCALE_MAX) begin
                        ovf_d    = 1'b1;
                        w_d      = 13'h07FF;
                        sticky_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        sticky_d = sticky_q | w_q[0];
                        w_d      = {1'b0, w_q[12:1]};
                        scale_d  = scale_q + 5'd1;
                    end
                end else if (scale_q == SCALE_MIN) begin
                    uf_d    = 1'b1;
                    w_d     = 13'd0;
                    state_d = DONE;
                end else begin
                    w_d     = {w_q[11:0], 1'b0};
                    scale_d = scale_q - 5'd1;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign scale_out_o = scale_q;
    assign frac_out_o  = w_q[10:0];
    assign zero_o      = zero_q;
    assign ovf_o       = ovf_q;
    assign uf_o        = uf_q;
`ifdef NORM_SEQ_STICKY_EN
    assign sticky_o    = sticky_q;
`endif

endmodule
